// File: rtl/sprite_frame_sequencer.sv
// -----------------------------------------------------------------------------
// sprite_frame_sequencer
//
// Per-frame command sequencer for the double-buffered sprite display blocks.
// The host fills a shadow table of sprite entries at any time. When vertical
// blank begins, every entry is replayed in index order onto the shared
// writedata bus. Each entry is replayed as update words written into the back
// buffer of its display block, followed by a buffer swap for that component.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   hcount         current pixel column; kept only so all blocks share one bus
//   vcount         current line; the rising edge into VBLANK_LINE starts a frame
//   cfg_write      host write strobe, one table word per cycle
//   cfg_addr       {entry index, word select}
//   cfg_writedata  table word (word 0: ids/flags, word 1: x/y position)
//   writedata      command word to the sprite display blocks (0 when idle)
//   busy           high while a frame is being sequenced
//   frame_done     one-cycle pulse after the last swap of a frame
//   overrun        one-cycle pulse when vblank starts while still sequencing
//   back_buf       index of the buffer currently being written
// -----------------------------------------------------------------------------
module sprite_frame_sequencer #(
    parameter int NUM_ENTRIES = 8,   // power of two, at least 2
    parameter int VBLANK_LINE = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    input  logic                          cfg_write,
    input  logic [$clog2(NUM_ENTRIES):0]  cfg_addr,
    input  logic [31:0]                   cfg_writedata,
    output logic [31:0]                   writedata,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    output logic                          back_buf
);

    localparam int              IW       = $clog2(NUM_ENTRIES);
    localparam int              AW       = IW + 1;
    localparam logic [9:0]      VBLANK_V = 10'(VBLANK_LINE);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_ENTRIES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_VIS  = 3'd2;
    localparam logic [2:0] S_XPOS = 3'd3;
    localparam logic [2:0] S_YPOS = 3'd4;
    localparam logic [2:0] S_SWAP = 3'd5;
    localparam logic [2:0] S_NEXT = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [3:0] ACT_UPDATE = 4'b0001;
    localparam logic [3:0] ACT_SWAP   = 4'b1111;
    localparam logic [2:0] TYPE_SWAP  = 3'b000;
    localparam logic [2:0] TYPE_VIS   = 3'b001;
    localparam logic [2:0] TYPE_XPOS  = 3'b010;
    localparam logic [2:0] TYPE_YPOS  = 3'b011;

    // Command word layout: [31:26] component, [25:21] child, [20:17] action,
    // [16:14] type, [13] target buffer, [12:0] payload.
    function automatic logic [31:0] vis_word(input logic [5:0] comp,
                                             input logic [4:0] child,
                                             input logic       buf_sel,
                                             input logic       vis,
                                             input logic       flip);
        return {comp, child, ACT_UPDATE, TYPE_VIS, buf_sel, vis, flip, 11'b0};
    endfunction

    function automatic logic [31:0] pos_word(input logic [5:0] comp,
                                             input logic [4:0] child,
                                             input logic [2:0] typ,
                                             input logic       buf_sel,
                                             input logic [9:0] val);
        return {comp, child, ACT_UPDATE, typ, buf_sel, 3'b000, val};
    endfunction

    function automatic logic [31:0] swap_word(input logic [5:0] comp,
                                              input logic [4:0] child,
                                              input logic       buf_sel);
        return {comp, child, ACT_SWAP, TYPE_SWAP, buf_sel, 13'b0};
    endfunction

    // ------------------------------------------------------------------------
    // Shadow table written by the host
    // ------------------------------------------------------------------------
    logic [5:0] tbl_comp_q  [NUM_ENTRIES];
    logic [4:0] tbl_child_q [NUM_ENTRIES];
    logic       tbl_en_q    [NUM_ENTRIES];
    logic       tbl_vis_q   [NUM_ENTRIES];
    logic       tbl_flip_q  [NUM_ENTRIES];
    logic [9:0] tbl_x_q     [NUM_ENTRIES];
    logic [9:0] tbl_y_q     [NUM_ENTRIES];

    logic [5:0] tbl_comp_d  [NUM_ENTRIES];
    logic [4:0] tbl_child_d [NUM_ENTRIES];
    logic       tbl_en_d    [NUM_ENTRIES];
    logic       tbl_vis_d   [NUM_ENTRIES];
    logic       tbl_flip_d  [NUM_ENTRIES];
    logic [9:0] tbl_x_d     [NUM_ENTRIES];
    logic [9:0] tbl_y_d     [NUM_ENTRIES];

    logic [IW-1:0] wr_idx;
    assign wr_idx = cfg_addr[AW-1:1];

    // Bits of the host word that no field decodes, plus the column counter.
    logic unused_ok;
    assign unused_ok = ^{hcount, cfg_writedata[15:10]};

    always_comb begin
        tbl_comp_d  = tbl_comp_q;
        tbl_child_d = tbl_child_q;
        tbl_en_d    = tbl_en_q;
        tbl_vis_d   = tbl_vis_q;
        tbl_flip_d  = tbl_flip_q;
        tbl_x_d     = tbl_x_q;
        tbl_y_d     = tbl_y_q;
        if (cfg_write) begin
            if (!cfg_addr[0]) begin
                tbl_comp_d[wr_idx]  = cfg_writedata[31:26];
                tbl_child_d[wr_idx] = cfg_writedata[25:21];
                tbl_en_d[wr_idx]    = cfg_writedata[20];
                tbl_vis_d[wr_idx]   = cfg_writedata[19];
                tbl_flip_d[wr_idx]  = cfg_writedata[18];
            end else begin
                tbl_x_d[wr_idx]     = cfg_writedata[25:16];
                tbl_y_d[wr_idx]     = cfg_writedata[9:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_comp_q[i]  <= '0;
                tbl_child_q[i] <= '0;
                tbl_en_q[i]    <= 1'b0;
                tbl_vis_q[i]   <= 1'b0;
                tbl_flip_q[i]  <= 1'b0;
                tbl_x_q[i]     <= '0;
                tbl_y_q[i]     <= '0;
            end
        end else begin
            tbl_comp_q  <= tbl_comp_d;
            tbl_child_q <= tbl_child_d;
            tbl_en_q    <= tbl_en_d;
            tbl_vis_q   <= tbl_vis_d;
            tbl_flip_q  <= tbl_flip_d;
            tbl_x_q     <= tbl_x_d;
            tbl_y_q     <= tbl_y_d;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer control
    // ------------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [9:0]    vcount_q, vcount_d;
    logic [31:0]   writedata_q, writedata_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;
    logic          back_buf_q, back_buf_d;

    // Working copy of the entry being replayed. Snapshotting it in LOAD keeps
    // the words of one entry consistent even if the host rewrites it mid-way.
    logic [5:0] w_comp_q, w_comp_d;
    logic [4:0] w_child_q, w_child_d;
    logic       w_vis_q, w_vis_d;
    logic       w_flip_q, w_flip_d;
    logic [9:0] w_x_q, w_x_d;
    logic [9:0] w_y_q, w_y_d;

    logic trigger;
    assign trigger  = (vcount == VBLANK_V) && (vcount_q != VBLANK_V);
    assign vcount_d = vcount;

    always_comb begin
        w_comp_d  = w_comp_q;
        w_child_d = w_child_q;
        w_vis_d   = w_vis_q;
        w_flip_d  = w_flip_q;
        w_x_d     = w_x_q;
        w_y_d     = w_y_q;
        if (state_q == S_LOAD) begin
            w_comp_d  = tbl_comp_q[idx_q];
            w_child_d = tbl_child_q[idx_q];
            w_vis_d   = tbl_vis_q[idx_q];
            w_flip_d  = tbl_flip_q[idx_q];
            w_x_d     = tbl_x_q[idx_q];
            w_y_d     = tbl_y_q[idx_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        writedata_d  = '0;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        back_buf_d   = back_buf_q;
        // busy stays up through the frame_done pulse so it covers the whole
        // frame including the final handshake cycle.
        busy_d       = frame_done_q ? 1'b0 : busy_q;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                // Disabled entries still get a swap: the back buffer was cleared
                // by the previous swap, so swapping alone hides the sprite.
                if (tbl_comp_q[idx_q] == 6'd0) begin
                    state_d = S_NEXT;
                end else if (!tbl_en_q[idx_q]) begin
                    state_d = S_SWAP;
                end else begin
                    state_d = S_VIS;
                end
            end
            S_VIS: begin
                writedata_d = vis_word(w_comp_q, w_child_q, back_buf_q, w_vis_q, w_flip_q);
                state_d     = S_XPOS;
            end
            S_XPOS: begin
                writedata_d = pos_word(w_comp_q, w_child_q, TYPE_XPOS, back_buf_q, w_x_q);
                state_d     = S_YPOS;
            end
            S_YPOS: begin
                writedata_d = pos_word(w_comp_q, w_child_q, TYPE_YPOS, back_buf_q, w_y_q);
                state_d     = S_SWAP;
            end
            S_SWAP: begin
                writedata_d = swap_word(w_comp_q, w_child_q, back_buf_q);
                state_d     = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                back_buf_d   = ~back_buf_q;
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new vblank while still sequencing is flagged and otherwise ignored.
        if (trigger && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            vcount_q     <= '0;
            writedata_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            back_buf_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vcount_q     <= vcount_d;
            writedata_q  <= writedata_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            back_buf_q   <= back_buf_d;
        end
    end

    // Working copy is only read after a LOAD has filled it, so it needs no reset.
    always_ff @(posedge clk) begin
        w_comp_q  <= w_comp_d;
        w_child_q <= w_child_d;
        w_vis_q   <= w_vis_d;
        w_flip_q  <= w_flip_d;
        w_x_q     <= w_x_d;
        w_y_q     <= w_y_d;
    end

    assign writedata  = writedata_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign back_buf   = back_buf_q;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for sprite_frame_sequencer.
// Each frame is triggered by a 479->480 vcount step; outputs are captured one
// time unit after every rising edge (index k = k-th edge after the trigger
// edge) and compared against a table of hand-computed records.
// -----------------------------------------------------------------------------
module tb_sprite_frame_sequencer;

    localparam int N    = 8;
    localparam int AW   = $clog2(N) + 1;
    localparam int CAPN = 24;
    localparam int NONE = -10;

    logic          clk           = 1'b0;
    logic          reset         = 1'b0;
    logic [9:0]    hcount        = '0;
    logic [9:0]    vcount        = '0;
    logic          cfg_write     = 1'b0;
    logic [AW-1:0] cfg_addr      = '0;
    logic [31:0]   cfg_writedata = '0;
    logic [31:0]   writedata;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic          back_buf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sprite_frame_sequencer #(
        .NUM_ENTRIES (N),
        .VBLANK_LINE (480)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hcount        (hcount),
        .vcount        (vcount),
        .cfg_write     (cfg_write),
        .cfg_addr      (cfg_addr),
        .cfg_writedata (cfg_writedata),
        .writedata     (writedata),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .back_buf      (back_buf)
    );

    typedef struct {
        int          scen;
        int          k;
        logic [31:0] wd;
        logic        busy;
        logic        fd;
        logic        bb;
        logic        ov;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] cap_wd   [CAPN];
    logic        cap_busy [CAPN];
    logic        cap_fd   [CAPN];
    logic        cap_bb   [CAPN];
    logic        cap_ov   [CAPN];

    function automatic void add(input int s, input int k, input logic [31:0] wd,
                                input logic b, input logic fd, input logic bb,
                                input logic ov);
        vecs.push_back('{s, k, wd, b, fd, bb, ov});
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic host_wr(input int idx, input int sel, input logic [31:0] data);
        @(negedge clk);
        cfg_write     = 1'b1;
        cfg_addr      = AW'(idx * 2 + sel);
        cfg_writedata = data;
        @(negedge clk);
        cfg_write     = 1'b0;
    endtask

    // Trigger a frame and capture ncyc edges. Optionally write word 1 of entry
    // wr_idx during cycle wr_k, and re-create a 479->480 step starting at ov_k.
    task automatic run_frame(input int ncyc, input int wr_k, input int wr_idx,
                             input logic [31:0] wr_data, input int ov_k);
        @(negedge clk);
        vcount = 10'd479;
        @(negedge clk);
        vcount = 10'd480;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            cap_wd[k]   = writedata;
            cap_busy[k] = busy;
            cap_fd[k]   = frame_done;
            cap_bb[k]   = back_buf;
            cap_ov[k]   = overrun;
            cfg_write   = 1'b0;
            if (k == wr_k) begin
                cfg_write     = 1'b1;
                cfg_addr      = AW'(wr_idx * 2 + 1);
                cfg_writedata = wr_data;
            end
            if (k == ov_k)     vcount = 10'd479;
            if (k == ov_k + 1) vcount = 10'd480;
        end
        @(negedge clk);
        cfg_write = 1'b0;
        vcount    = 10'd0;
    endtask

    task automatic check_scen(input int s, input int ncyc, input int exp_nz, input int exp_ov);
        int nz = 0;
        int ov = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (cap_wd[k] != 32'd0) nz++;
            if (cap_ov[k]) ov++;
        end
        chk32($sformatf("s%0d_word_count", s), 32'(nz), 32'(exp_nz));
        chk32($sformatf("s%0d_overrun_count", s), 32'(ov), 32'(exp_ov));
        foreach (vecs[i]) begin
            if (vecs[i].scen == s) begin
                chk32($sformatf("s%0d_k%0d_writedata", s, vecs[i].k), cap_wd[vecs[i].k], vecs[i].wd);
                chk1($sformatf("s%0d_k%0d_busy", s, vecs[i].k), cap_busy[vecs[i].k], vecs[i].busy);
                chk1($sformatf("s%0d_k%0d_frame_done", s, vecs[i].k), cap_fd[vecs[i].k], vecs[i].fd);
                chk1($sformatf("s%0d_k%0d_back_buf", s, vecs[i].k), cap_bb[vecs[i].k], vecs[i].bb);
                chk1($sformatf("s%0d_k%0d_overrun", s, vecs[i].k), cap_ov[vecs[i].k], vecs[i].ov);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // scen 1: entry0 comp 9 enabled visible x=100 y=200, back_buf=1
        add(1, 0,  32'h00000000, 1, 0, 1, 0);
        add(1, 1,  32'h00000000, 1, 0, 1, 0);
        add(1, 2,  32'h24027000, 1, 0, 1, 0);
        add(1, 3,  32'h2402A064, 1, 0, 1, 0);
        add(1, 4,  32'h2402E0C8, 1, 0, 1, 0);
        add(1, 5,  32'h241E2000, 1, 0, 1, 0);
        add(1, 6,  32'h00000000, 1, 0, 1, 0);
        add(1, 20, 32'h00000000, 1, 0, 1, 0);
        add(1, 21, 32'h00000000, 1, 1, 0, 0);
        add(1, 22, 32'h00000000, 0, 0, 0, 0);
        // scen 2: same table, back_buf=0
        add(2, 2,  32'h24025000, 1, 0, 0, 0);
        add(2, 3,  32'h24028064, 1, 0, 0, 0);
        add(2, 4,  32'h2402C0C8, 1, 0, 0, 0);
        add(2, 5,  32'h241E0000, 1, 0, 0, 0);
        add(2, 21, 32'h00000000, 1, 1, 1, 0);
        add(2, 22, 32'h00000000, 0, 0, 1, 0);
        // scen 3: entry0 disabled, swap only
        add(3, 1,  32'h00000000, 1, 0, 1, 0);
        add(3, 2,  32'h241E2000, 1, 0, 1, 0);
        add(3, 3,  32'h00000000, 1, 0, 1, 0);
        add(3, 17, 32'h00000000, 1, 0, 1, 0);
        add(3, 18, 32'h00000000, 1, 1, 0, 0);
        add(3, 19, 32'h00000000, 0, 0, 0, 0);
        // scen 4: x rewritten to 300 during XPOS, this frame still uses 100
        add(4, 2,  32'h24025000, 1, 0, 0, 0);
        add(4, 3,  32'h24028064, 1, 0, 0, 0);
        add(4, 4,  32'h2402C0C8, 1, 0, 0, 0);
        add(4, 5,  32'h241E0000, 1, 0, 0, 0);
        add(4, 21, 32'h00000000, 1, 1, 1, 0);
        // scen 5: x=300 now visible; second vblank edge mid-frame
        add(5, 2,  32'h24027000, 1, 0, 1, 0);
        add(5, 3,  32'h2402A12C, 1, 0, 1, 0);
        add(5, 4,  32'h2402E0C8, 1, 0, 1, 0);
        add(5, 5,  32'h241E2000, 1, 0, 1, 0);
        add(5, 6,  32'h00000000, 1, 0, 1, 0);
        add(5, 7,  32'h00000000, 1, 0, 1, 1);
        add(5, 8,  32'h00000000, 1, 0, 1, 0);
        add(5, 21, 32'h00000000, 1, 1, 0, 0);
        add(5, 22, 32'h00000000, 0, 0, 0, 0);
        // scen 6: partial frame, cut by reset during YPOS
        add(6, 0,  32'h00000000, 1, 0, 0, 0);
        add(6, 2,  32'h24025000, 1, 0, 0, 0);
        add(6, 3,  32'h2402812C, 1, 0, 0, 0);
        // scen 7: table cleared by reset, empty frame
        add(7, 0,  32'h00000000, 1, 0, 1, 0);
        add(7, 16, 32'h00000000, 1, 0, 1, 0);
        add(7, 17, 32'h00000000, 1, 1, 0, 0);
        add(7, 18, 32'h00000000, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk32("reset_writedata", writedata, 32'h0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_frame_done", frame_done, 1'b0);
        chk1("reset_overrun", overrun, 1'b0);
        chk1("reset_back_buf", back_buf, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        host_wr(0, 0, 32'h24180000);
        host_wr(0, 1, 32'h006400C8);
        run_frame(CAPN, NONE, 0, 32'h0, NONE);
        check_scen(1, CAPN, 4, 0);

        run_frame(CAPN, NONE, 0, 32'h0, NONE);
        check_scen(2, CAPN, 4, 0);

        host_wr(0, 0, 32'h24080000);
        run_frame(CAPN, NONE, 0, 32'h0, NONE);
        check_scen(3, CAPN, 1, 0);

        host_wr(0, 0, 32'h24180000);
        run_frame(CAPN, 2, 0, 32'h012C00C8, NONE);
        check_scen(4, CAPN, 4, 0);

        run_frame(CAPN, NONE, 0, 32'h0, 5);
        check_scen(5, CAPN, 4, 1);

        // Stop after the XPOS word; the following negedge is inside YPOS.
        run_frame(4, NONE, 0, 32'h0, NONE);
        check_scen(6, 4, 2, 0);
        reset = 1'b0;
        #1;
        chk32("async_reset_writedata", writedata, 32'h0);
        chk1("async_reset_busy", busy, 1'b0);
        chk1("async_reset_back_buf", back_buf, 1'b1);
        chk1("async_reset_frame_done", frame_done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("post_reset_idle_busy", busy, 1'b0);
        chk32("post_reset_idle_writedata", writedata, 32'h0);

        run_frame(CAPN, NONE, 0, 32'h0, NONE);
        check_scen(7, CAPN, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
